// File: rtl/g_alu_seq.sv
// g_alu_seq: handshaked RV32I-style ALU with a one-entry output register and an iterative shifter.
// Non-shift ops and zero-amount shifts complete at the accept edge; other shifts step SHIFT_STEP bits per cycle.
module g_alu_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int TAG_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  input0_i,
  input  logic [XLEN-1:0]  input1_i,
  input  logic [2:0]       funct3_i,
  input  logic             funct7_i,
  input  logic             op_imm_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  output_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int SW = $clog2(XLEN);
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] STEP = RW'(SHIFT_STEP);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_nxt;

  logic [XLEN-1:0]  r_work, r_out;
  logic [RW-1:0]    r_rem;
  logic             r_left, r_arith, r_valid, r_zero, r_carry, r_ovf;
  logic [TAG_W-1:0] r_ptag, r_tag;

  logic             w_accept, w_sub, w_multi, w_load, w_done, w_ovf, w_carry;
  logic [SW-1:0]    w_shamt;
  logic [XLEN-1:0]  w_b, w_alu, w_res, w_sra, w_shifted;
  logic [XLEN:0]    w_sum;
  logic [RW-1:0]    w_s, w_rem_nxt;

  assign w_shamt = input1_i[SW-1:0];
  assign w_sub   = funct3_i == 3'd0 && funct7_i && !op_imm_i;
  assign w_b     = w_sub ? ~input1_i : input1_i;
  assign w_sum   = {1'b0, input0_i} + {1'b0, w_b} + (XLEN+1)'(w_sub);
  assign w_ovf   = (input0_i[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != input0_i[XLEN-1]);
  assign w_carry = funct3_i == 3'd0 && w_sum[XLEN];
  assign w_multi = (funct3_i == 3'd1 || funct3_i == 3'd5) && w_shamt != '0;

  always_comb begin
    w_alu = input0_i;
    case (funct3_i)
      3'd0:    w_alu = w_sum[XLEN-1:0];
      3'd2:    w_alu = XLEN'($signed(input0_i) < $signed(input1_i));
      3'd3:    w_alu = XLEN'(input0_i < input1_i);
      3'd4:    w_alu = input0_i ^ input1_i;
      3'd6:    w_alu = input0_i | input1_i;
      3'd7:    w_alu = input0_i & input1_i;
      default: w_alu = input0_i;
    endcase
  end

  // Last step may be shorter than SHIFT_STEP so the total never overshoots shamt
  assign w_s       = r_rem < STEP ? r_rem : STEP;
  assign w_rem_nxt = r_rem - w_s;
  assign w_sra     = $signed(r_work) >>> w_s;
  assign w_shifted = r_left ? r_work << w_s : r_arith ? w_sra : r_work >> w_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = flush_i ? IDLE :
                  (r_state == IDLE && w_accept && w_multi) ? SHIFT :
                  (r_state == SHIFT && w_rem_nxt == '0) ? IDLE : r_state;
  end

  always_comb begin
    in_ready_o = r_state == IDLE && (!r_valid || out_ready_i) && !flush_i;
    w_accept   = in_valid_i && in_ready_o;
    w_done     = r_state == SHIFT && w_rem_nxt == '0;
    w_load     = !flush_i && ((w_accept && !w_multi) || w_done);
    w_res      = w_done ? w_shifted : w_alu;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_rem   <= '0;
      r_work  <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
      r_ptag  <= '0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_tag   <= '0;
    end else begin
      r_valid <= flush_i ? 1'b0 : w_load ? 1'b1 : r_valid && !out_ready_i;
      r_rem   <= flush_i ? '0 : (w_accept && w_multi) ? RW'(w_shamt) : r_state == SHIFT ? w_rem_nxt : r_rem;
      if (w_accept && w_multi) begin
        r_work  <= input0_i;
        r_left  <= funct3_i == 3'd1;
        r_arith <= funct7_i;
        r_ptag  <= tag_i;
      end else if (r_state == SHIFT && !flush_i) begin
        r_work <= w_shifted;
      end
      if (w_load) begin
        r_out   <= w_res;
        r_zero  <= w_res == '0;
        r_carry <= !w_done && w_carry;
        r_ovf   <= !w_done && funct3_i == 3'd0 && w_ovf;
        r_tag   <= w_done ? r_ptag : tag_i;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign output_o    = r_out;
  assign zero_o      = r_zero;
  assign carry_o     = r_carry;
  assign overflow_o  = r_ovf;
  assign tag_o       = r_tag;
endmodule

// File: tb/tb_g_alu_seq.sv
// tb_g_alu_seq: directed bench for g_alu_seq, SHIFT_STEP=1 main instance plus a SHIFT_STEP=4 instance for shift latency.
module tb_g_alu_seq;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_valid4 = 0, out_ready = 1;
  logic [31:0] in0 = 0, in1 = 0;
  logic [2:0]  f3 = 0;
  logic        f7 = 0, imm = 0;
  logic [3:0]  tag = 0;
  logic        in_ready, valid, zero, carry, ovf;
  logic [31:0] out;
  logic [3:0]  tag_o;
  logic        in_ready4, valid4, zero4, carry4, ovf4;
  logic [31:0] out4;
  logic [3:0]  tag4;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  g_alu_seq #(.XLEN(32), .SHIFT_STEP(1), .TAG_W(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .input0_i(in0), .input1_i(in1), .funct3_i(f3), .funct7_i(f7), .op_imm_i(imm), .tag_i(tag),
    .out_valid_o(valid), .out_ready_i(out_ready), .output_o(out), .zero_o(zero),
    .carry_o(carry), .overflow_o(ovf), .tag_o(tag_o));

  g_alu_seq #(.XLEN(32), .SHIFT_STEP(4), .TAG_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .input0_i(in0), .input1_i(in1), .funct3_i(f3), .funct7_i(f7), .op_imm_i(imm), .tag_i(tag),
    .out_valid_o(valid4), .out_ready_i(1'b1), .output_o(out4), .zero_o(zero4),
    .carry_o(carry4), .overflow_o(ovf4), .tag_o(tag4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic s7, input logic im, input logic [3:0] t);
    in0 = a; in1 = b; f3 = f; f7 = s7; imm = im; tag = t; in_valid = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) tick();
    checks++;
    if ({valid, out, zero, carry, ovf, tag_o} !== 42'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {valid, out, zero, carry, ovf, tag_o});
    end
    rst_n = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(32'hFFFF_FFFF, 32'h1, 3'd0, 0, 0, 4'd3);
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, zero, carry, ovf, tag_o} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL add got=%h exp=%h", {valid, out, zero, carry, ovf, tag_o}, {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 4'd3});
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h8000_0000, 32'h1, 3'd0, 1, 0, 4'd1);
    tick();
    checks++;
    if ({valid, out, carry, ovf, tag_o} !== {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL sub got=%h exp=%h", {valid, out, carry, ovf, tag_o}, {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 4'd1});
    end
    drive(32'h8000_0000, 32'h1, 3'd0, 1, 1, 4'd2);
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, carry, ovf, tag_o} !== {1'b1, 32'h8000_0001, 1'b0, 1'b0, 4'd2}) begin
      failures++;
      $display("FAIL addi got=%h exp=%h", {valid, out, carry, ovf, tag_o}, {1'b1, 32'h8000_0001, 1'b0, 1'b0, 4'd2});
    end
    tick();
    checks++;
    if ({valid, out} !== {1'b0, 32'h8000_0001}) begin
      failures++;
      $display("FAIL drain got=%h exp=%h", {valid, out}, {1'b0, 32'h8000_0001});
    end
  endtask

  task automatic test_slt();
    drive(32'hFFFF_FFFF, 32'h1, 3'd2, 0, 0, 4'd4);
    tick();
    checks++;
    if ({valid, out, zero, carry, ovf} !== {1'b1, 32'h1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL slt got=%h exp=%h", {valid, out, zero, carry, ovf}, {1'b1, 32'h1, 1'b0, 1'b0, 1'b0});
    end
    drive(32'hFFFF_FFFF, 32'h1, 3'd3, 0, 0, 4'd5);
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, zero, carry, ovf} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sltu got=%h exp=%h", {valid, out, zero, carry, ovf}, {1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_shift();
    int lat1, lat4, lowrdy;
    logic [38:0] res1, res4;
    lat1 = 0; lat4 = 0; lowrdy = 0; res1 = '0; res4 = '0;
    drive(32'h8000_0000, 32'd5, 3'd5, 1, 0, 4'd9);
    in_valid4 = 1;
    tick();
    in_valid = 0;
    in_valid4 = 0;
    for (int i = 1; i <= 10; i++) begin
      if (!in_ready) lowrdy++;
      if (valid && lat1 == 0) begin lat1 = i; res1 = {out, zero, carry, ovf, tag_o}; end
      if (valid4 && lat4 == 0) begin lat4 = i; res4 = {out4, zero4, carry4, ovf4, tag4}; end
      tick();
    end
    checks++;
    if (lat1 !== 6) begin failures++; $display("FAIL sra_latency_step1 got=%0d exp=6", lat1); end
    checks++;
    if (lat4 !== 3) begin failures++; $display("FAIL sra_latency_step4 got=%0d exp=3", lat4); end
    checks++;
    if (lowrdy !== 5) begin failures++; $display("FAIL sra_ready_low got=%0d exp=5", lowrdy); end
    checks++;
    if (res1 !== {32'hFC00_0000, 3'b000, 4'd9}) begin
      failures++;
      $display("FAIL sra_result_step1 got=%h exp=%h", res1, {32'hFC00_0000, 3'b000, 4'd9});
    end
    checks++;
    if (res4 !== {32'hFC00_0000, 3'b000, 4'd9}) begin
      failures++;
      $display("FAIL sra_result_step4 got=%h exp=%h", res4, {32'hFC00_0000, 3'b000, 4'd9});
    end
    drive(32'h0000_1234, 32'hFFFF_FFE0, 3'd1, 0, 0, 4'd6);
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, tag_o} !== {1'b1, 32'h1234, 4'd6}) begin
      failures++;
      $display("FAIL sll_shamt0 got=%h exp=%h", {valid, out, tag_o}, {1'b1, 32'h1234, 4'd6});
    end
    tick();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    out_ready = 0;
    drive(32'hA5, 32'h50, 3'd6, 0, 0, 4'd7);
    tick();
    drive(32'hF0F0, 32'h0FF0, 3'd4, 0, 0, 4'd2);
    checks++;
    if ({valid, out, tag_o} !== {1'b1, 32'hF5, 4'd7}) begin
      failures++;
      $display("FAIL or_pending got=%h exp=%h", {valid, out, tag_o}, {1'b1, 32'hF5, 4'd7});
    end
    for (int i = 0; i < 10; i++) begin
      if ({in_ready, valid, out, tag_o} !== {1'b0, 1'b1, 32'hF5, 4'd7}) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    out_ready = 1;
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, tag_o} !== {1'b1, 32'hFF00, 4'd2}) begin
      failures++;
      $display("FAIL drain_accept got=%h exp=%h", {valid, out, tag_o}, {1'b1, 32'hFF00, 4'd2});
    end
    tick();
    checks++;
    if ({valid, out} !== {1'b0, 32'hFF00}) begin
      failures++;
      $display("FAIL drain_hold got=%h exp=%h", {valid, out}, {1'b0, 32'hFF00});
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    drive(32'hFFFF_FFFF, 32'd20, 3'd5, 0, 0, 4'd5);
    tick();
    in_valid = 0;
    repeat (2) tick();
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_during got=%b exp=0", in_ready); end
    tick();
    flush = 0;
    #1;
    checks++;
    if ({valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL flush_after got=%b exp=01", {valid, in_ready});
    end
    for (int i = 0; i < 25; i++) begin
      if (valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
    drive(32'hFFFF, 32'h0F0F, 3'd7, 0, 0, 4'd1);
    tick();
    in_valid = 0;
    checks++;
    if ({valid, out, tag_o} !== {1'b1, 32'h0F0F, 4'd1}) begin
      failures++;
      $display("FAIL and_after_flush got=%h exp=%h", {valid, out, tag_o}, {1'b1, 32'h0F0F, 4'd1});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    drive(32'h1, 32'd10, 3'd1, 0, 0, 4'd4);
    tick();
    in_valid = 0;
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({valid, out, zero, carry, ovf, tag_o, valid4, out4, tag4} !== 79'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {valid, out, zero, carry, ovf, tag_o, valid4, out4, tag4});
    end
    #1 rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (valid) seen++;
    end
    checks++;
    if ({seen != 0, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_abandon got=%0d results ready=%b exp=0 results ready=1", seen, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_slt();
    test_shift();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
